// File: rtl/vsqrt_iter.sv
// vsqrt_iter: multi-lane IEEE binary16 square root using a radix-2 restoring
// digit recurrence. Each lane resolves one root bit per cycle for 12 cycles.
// Special operands (zero, inf, NaN, negative values) still take the full 12
// cycles, and their result is selected when the output register is loaded.
// Optional build macro: VSQRT_SUBNORMAL_EN. When it is defined, positive
// subnormals are normalised and then rooted. When it is not defined, they
// flush to +0.
module vsqrt_iter #(
  parameter int LANES = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*LANES-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*LANES-1:0]  out_data,
  output logic [LANES-1:0]     out_nv
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       accept, last_iter;

  // Returns the left shift that moves the leading one of a subnormal
  // mantissa up to bit 10.
  function automatic logic [3:0] norm_shift(input logic [9:0] m);
    norm_shift = 4'd10;
    for (int i = 0; i < 10; i++)
      if (m[i]) norm_shift = 4'(10 - i);
  endfunction

  // Returns the unbiased exponent. For a subnormal this includes the
  // normalisation shift.
  function automatic logic signed [6:0] unb_exp(input logic [15:0] op);
    if (op[14:10] == 5'd0)
      unb_exp = -7'sd14 - $signed({3'b000, norm_shift(op[9:0])});
    else
      unb_exp = $signed({2'b00, op[14:10]}) - 7'sd15;
  endfunction

  // Returns the 11-bit significand with its leading one at bit 10.
  function automatic logic [10:0] sig_of(input logic [15:0] op);
    if (op[14:10] == 5'd0)
      sig_of = {1'b0, op[9:0]} << norm_shift(op[9:0]);
    else
      sig_of = {1'b1, op[9:0]};
  endfunction

  assign accept    = in_valid && (state_reg == IDLE);
  assign last_iter = (state_reg == CALC) && (cnt_reg == 4'd11);
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

  // State and iteration counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: accept a vector, count 12 iterations, then wait for
  // the consumer to take the result.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (in_valid) begin
        state_next = CALC;
        cnt_next   = 4'd0;
      end
      CALC: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd11) state_next = DONE;
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [15:0] in_lane, op_reg;
      logic [23:0] rad_in, rad_reg;
      logic [11:0] rem_reg;
      logic [10:0] q_reg;
      logic [13:0] rem_sh, trial, rem_next;
      logic [11:0] q_next, sum;
      logic        ge, inc;
      logic signed [6:0] e_in, er;
      logic [6:0]  biased;
      logic [15:0] norm_val, spec_val, res_reg;
      logic        spec_hit, spec_nv, nv_reg;

      assign in_lane = in_data[16*gi +: 16];

      // Build the radicand sig << (12 + odd) at accept time.
      always_comb begin
        e_in   = unb_exp(in_lane);
        rad_in = e_in[0] ? {sig_of(in_lane), 13'd0} : {1'b0, sig_of(in_lane), 12'd0};
      end

      // One restoring step: bring down two radicand bits and try root bit 1.
      always_comb begin
        rem_sh   = {rem_reg, rad_reg[23:22]};
        trial    = {1'b0, q_reg, 2'b01};
        ge       = (rem_sh >= trial);
        rem_next = ge ? (rem_sh - trial) : rem_sh;
        q_next   = {q_reg, ge};
      end

      // Round the final root to nearest even and pack the result. A carry
      // out of rounding bumps the exponent and leaves a zero mantissa.
      always_comb begin
        er       = unb_exp(op_reg) >>> 1;
        inc      = q_next[0] & ((rem_next != 14'd0) | q_next[1]);
        sum      = {1'b0, q_next[11:1]} + {11'd0, inc};
        biased   = er + 7'd15 + {6'd0, sum[11]};
        norm_val = {1'b0, biased[4:0], sum[11] ? 10'd0 : sum[9:0]};
      end

      // Classify the operand and decide whether it needs a special result.
      always_comb begin
        spec_hit = 1'b1;
        spec_val = 16'h7E00;
        spec_nv  = 1'b0;
        if (op_reg[14:10] == 5'h1F) begin
          if (op_reg[9:0] != 10'd0) spec_nv = ~op_reg[9];
          else if (op_reg[15])      spec_nv = 1'b1;
          else                      spec_val = 16'h7C00;
        end else if (op_reg[14:0] == 15'd0) begin
          spec_val = op_reg;
        end else if (op_reg[15]) begin
          spec_nv = 1'b1;
        end else if (op_reg[14:10] == 5'd0) begin
`ifdef VSQRT_SUBNORMAL_EN
          spec_hit = 1'b0;
`else
          spec_val = 16'h0000;
`endif
        end else begin
          spec_hit = 1'b0;
        end
      end

      // Per-lane datapath state: capture on accept, iterate in CALC, and
      // load the output on the last iteration.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          op_reg  <= 16'd0;
          rad_reg <= 24'd0;
          rem_reg <= 12'd0;
          q_reg   <= 11'd0;
          res_reg <= 16'd0;
          nv_reg  <= 1'b0;
        end else if (accept) begin
          op_reg  <= in_lane;
          rad_reg <= rad_in;
          rem_reg <= 12'd0;
          q_reg   <= 11'd0;
        end else if (state_reg == CALC) begin
          rad_reg <= rad_reg << 2;
          rem_reg <= rem_next[11:0];
          q_reg   <= q_next[10:0];
          if (last_iter) begin
            res_reg <= spec_hit ? spec_val : norm_val;
            nv_reg  <= spec_hit & spec_nv;
          end
        end
      end

      assign out_data[16*gi +: 16] = res_reg;
      assign out_nv[gi]            = nv_reg;
    end
  endgenerate

endmodule

// File: tb/tb_vsqrt_iter.sv
// Testbench for vsqrt_iter (LANES=4). It uses directed and random operand
// vectors with a scoreboard queue of expected {nv, data}.
module tb_vsqrt_iter;
  localparam int L = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [16*L-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [16*L-1:0] out_data;
  logic [L-1:0]  out_nv;

  int n_checks = 0;
  int n_fail   = 0;
  logic [67:0] exp_q[$];

  vsqrt_iter #(.LANES(L)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_nv(out_nv)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference result {nv, data} for one binary16 operand.
  function automatic logic [16:0] model(input logic [15:0] x);
    int e, er, odd, q, t, res, inc;
    longint rad, r;
    logic [10:0] sig;
    logic [4:0] ex;
    logic [9:0] m;
    ex = x[14:10];
    m  = x[9:0];
    if (ex == 5'h1F) begin
      if (m != 0) return {~m[9], 16'h7E00};
      return x[15] ? {1'b1, 16'h7E00} : {1'b0, 16'h7C00};
    end
    if (ex == 0 && m == 0) return {1'b0, x};
    if (x[15]) return {1'b1, 16'h7E00};
    if (ex == 0) begin
`ifdef VSQRT_SUBNORMAL_EN
      int lz;
      lz  = 0;
      sig = {1'b0, m};
      while (!sig[10]) begin sig = sig << 1; lz++; end
      e = -14 - lz;
`else
      return 17'h0;
`endif
    end else begin
      sig = {1'b1, m};
      e   = int'(ex) - 15;
    end
    er  = e >>> 1;
    odd = e & 1;
    rad = longint'(sig) << (12 + odd);
    q = 0;
    for (int b = 11; b >= 0; b--) begin
      t = q | (1 << b);
      if (longint'(t) * t <= rad) q = t;
    end
    r   = rad - longint'(q) * q;
    inc = ((q & 1) != 0 && (r != 0 || (q & 2) != 0)) ? 1 : 0;
    res = (q >> 1) + inc;
    if (res == 2048) begin res = 1024; er++; end
    return {1'b0, 1'b0, 5'(er + 15), 10'(res)};
  endfunction

  function automatic logic [67:0] model_vec(input logic [63:0] v);
    logic [16:0] m;
    logic [67:0] e;
    e = '0;
    for (int i = 0; i < L; i++) begin
      m = model(v[16*i +: 16]);
      e[16*i +: 16] = m[15:0];
      e[64 + i]     = m[16];
    end
    return e;
  endfunction

  task automatic send(input logic [63:0] v);
    @(negedge CLK);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_data  = ~v;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge CLK);
      if (out_valid) break;
      @(posedge CLK);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd12);
  endtask

  task automatic check_out(input string tag);
    logic [67:0] e;
    e = exp_q.pop_front();
    chk({tag, "_data"}, out_data, e[63:0]);
    chk({tag, "_nv"}, {60'd0, out_nv}, {60'd0, e[67:64]});
    $display("txn %s: out_data=%h out_nv=%b expected=%h/%b", tag, out_data, out_nv, e[63:0], e[67:64]);
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [63:0] v, input logic [67:0] e);
    exp_q.push_back(e);
    send(v);
    wait_out(tag);
    check_out(tag);
    finish_out(tag);
  endtask

  initial begin
    logic [63:0] v, snap;
    logic [15:0] sub_exp;
    logic        seen;

    // Reset state.
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_nv", {60'd0, out_nv}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge CLK);
    nRST = 1'b1;

    // Basic roots.
    run_op("basic", {16'h3C00, 16'h3400, 16'h4000, 16'h4400},
           {4'b0000, 16'h3C00, 16'h3800, 16'h3DA8, 16'h4000});
    // Near-halfway operands that must round down.
    run_op("halfway", {16'h3BFF, 16'h7BFF, 16'h3BFF, 16'h7BFF},
           {4'b0000, 16'h3BFF, 16'h5BFF, 16'h3BFF, 16'h5BFF});
    // Special operands: -1, -inf, sNaN, -0.
    run_op("special", {16'h8000, 16'h7C01, 16'hFC00, 16'hBC00},
           {4'b0111, 16'h8000, 16'h7E00, 16'h7E00, 16'h7E00});
    // Smallest subnormal, qNaN, +inf, +0.
`ifdef VSQRT_SUBNORMAL_EN
    sub_exp = 16'h0C00;
`else
    sub_exp = 16'h0000;
`endif
    run_op("subnormal", {16'h0000, 16'h7C00, 16'h7E00, 16'h0001},
           {4'b0000, 16'h0000, 16'h7C00, 16'h7E00, sub_exp});

    // Random positive normals, then random values of any class.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < L; i++)
        v[16*i +: 16] = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom)};
      run_op("rand_norm", v, model_vec(v));
    end
    for (int k = 0; k < 3; k++) begin
      v = {32'($urandom), 32'($urandom)};
      run_op("rand_any", v, model_vec(v));
    end

    // Back-pressure: hold out_ready low in DONE for 5 cycles.
    v = {16'h0200, 16'h5640, 16'h4400, 16'h8001};
    exp_q.push_back(model_vec(v));
    send(v);
    wait_out("stall");
    snap = out_data;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = {32'($urandom), 32'($urandom)};
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      @(negedge CLK);
      chk("stall_data_stable", out_data, snap);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
    end
    check_out("stall");
    finish_out("stall");

    // Reset at CALC iteration 6 abandons the operation.
    send({16'h4400, 16'h4400, 16'h4400, 16'h4400});
    repeat (6) @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", {63'd0, seen}, 64'd0);
    run_op("after_rst", {16'h3C00, 16'h3400, 16'h4000, 16'h4400},
           {4'b0000, 16'h3C00, 16'h3800, 16'h3DA8, 16'h4000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vsqrt_iter.md
VSQRT_ITER -- requirements
Module: vsqrt_iter

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning the number of independent fp16 lanes processed in lockstep (1..16).
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port nRST  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand vector valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand vector.
REQ-006 SHALL have port in_data  input  16*LANES  operands, lane i at bits [16i+15:16i], IEEE binary16.
REQ-007 SHALL have port out_valid  output  1  result vector valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port out_data  output  16*LANES  square roots, same lane packing as in_data.
REQ-010 SHALL have port out_nv  output  LANES  per-lane invalid-operation flag.

Function
REQ-011 SHALL use FSM states IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-012 SHALL accept on the edge with in_valid&in_ready, capture all lanes, enter CALC and clear a 4-bit iteration counter.
REQ-013 SHALL, in CALC, resolve one root bit per lane per cycle (radix-2 non-restoring or restoring digit recurrence), for 12 iterations.
REQ-014 SHALL register rounded results on the 12th CALC edge and enter DONE, so out_valid rises exactly 12 cycles after the accept edge, for every operand class.
REQ-015 SHALL hold out_data and out_nv stable in DONE until out_valid&out_ready, then return to IDLE; the next accept is at least 1 cycle later.
REQ-016 SHALL ignore in_data and in_valid outside IDLE, and leave out_ready without effect outside DONE.
REQ-017 SHALL, per normal lane, use sig = {1,mant} (11 bits), E = exp-15, Er = floor(E/2) and odd = E[0].
REQ-018 SHALL compute q = floor(sqrt(sig<<(12+odd))) (12 bits), remainder r, guard = q[0] and sticky = (r!=0).
REQ-019 SHALL round to nearest-even: inc = guard&(sticky|q[1]); res = q[11:1]+inc.
REQ-020 SHALL, when rounding carries to 2.0, output mantissa 0 with Er+1.
REQ-021 SHALL output {0, Er+15, res[9:0]}; results are always normal and never overflow.
REQ-022 SHALL output +0 for +0 and -0 for -0, with nv=0.
REQ-023 SHALL output +inf (0x7C00) for +inf, with nv=0.
REQ-024 SHALL output qNaN 0x7E00 for any NaN input, with nv=1 for sNaN (mant[9]=0) and nv=0 for qNaN.
REQ-025 SHALL output 0x7E00 with nv=1 for a negative nonzero input, including -inf and negative subnormals.
REQ-026 SHALL still spend 12 CALC cycles on special-case lanes, muxing in the special result at the DONE load.

Reset
REQ-027 SHALL, while nRST=0, force state IDLE, counter 0, out_data 0, out_nv 0, out_valid 0 and in_ready 1 after release.
REQ-028 SHALL, on reset asserted mid-CALC or in DONE, abandon the operation with no result emitted.

Configuration
REQ-029 SHALL, with macro VSQRT_SUBNORMAL_EN defined, normalise positive subnormals: shift mant left by lz until bit 10 set, E = -14-lz, then compute per REQ-017..021, giving biased results 3..7.
REQ-030 SHALL, without VSQRT_SUBNORMAL_EN, flush positive subnormals to 0x0000 (nv=0) and treat negative subnormals per REQ-025.

Verification
REQ-031 SHALL cover: lanes {0x4400,0x4000,0x3400,0x3C00} -> out_data {0x4000,0x3DA8,0x3800,0x3C00}, nv=0, out_valid exactly 12 cycles after accept.
REQ-032 SHALL cover: 0x7BFF -> 0x5BFF (near-halfway, rounds down); 0x3BFF -> 0x3BFF.
REQ-033 SHALL cover: {0xBC00,0xFC00,0x7C01,0x8000} -> {0x7E00,0x7E00,0x7E00,0x8000}, nv={1,1,1,0}.
REQ-034 SHALL cover: 0x0001 -> 0x0C00 with VSQRT_SUBNORMAL_EN and 0x0000 without.
REQ-035 SHALL cover: out_ready held low 5 cycles in DONE -> out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-036 SHALL cover: nRST asserted at CALC iteration 6 -> out_valid never rises, in_ready=1 after release, and the next operand completes correctly.
